// File: rtl/lap_timer_if.sv
// Button inputs and time/lap outputs of the lap timer.
// The timer side uses master; the button source and stash side use slave.
interface lap_timer_if;
    logic       start_stop;
    logic       lap_clear;
    logic [7:0] time_bcd;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       running;

    modport master (
        input  start_stop, lap_clear,
        output time_bcd, sample_out, sample_valid, running
    );

    modport slave (
        output start_stop, lap_clear,
        input  time_bcd, sample_out, sample_valid, running
    );
endinterface

// File: rtl/lap_timer.sv
// Two-digit BCD seconds stopwatch with run/pause, lap capture and clear.
// Lap samples leave as one-cycle strobes that feed the sample stash directly.
module lap_timer #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter logic [7:0]  WRAP_BCD = 8'h59
) (
    input logic         clk,
    input logic         reset,
    lap_timer_if.master bus
);
    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {PAUSED = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_next;
    logic [1:0]    ss_sync, lap_sync;
    logic          ss_d, lap_d;
    logic          ss_edge, lap_edge;
    logic          is_run, tick, do_lap, do_clear;
    logic [PW-1:0] presc;
    logic [7:0]    time_q;
    logic [7:0]    sample_q;
    logic          sample_valid_q;

    // Two-flop synchronizers followed by rising-edge detectors.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_sync  <= 2'b00;
            lap_sync <= 2'b00;
            ss_d     <= 1'b0;
            lap_d    <= 1'b0;
        end else begin
            ss_sync  <= {ss_sync[0], bus.start_stop};
            lap_sync <= {lap_sync[0], bus.lap_clear};
            ss_d     <= ss_sync[1];
            lap_d    <= lap_sync[1];
        end
    end

    assign ss_edge  = ss_sync[1] & ~ss_d;
    assign lap_edge = lap_sync[1] & ~lap_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PAUSED;
        else       state <= state_next;
    end

    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        if (ss_edge) state_next = (state == RUN) ? PAUSED : RUN;
    end

    // Actions decode from the pre-transition state, so coincident events act on it.
    always_comb begin
        is_run   = (state == RUN);
        tick     = is_run && (presc == PRESC_LAST);
        do_lap   = lap_edge && is_run;
        do_clear = lap_edge && !is_run;
    end

    function automatic logic [7:0] bcd_inc(input logic [7:0] t);
        logic [7:0] r;
        r = {t[7:4], t[3:0] + 4'd1};
        if (t == WRAP_BCD)       r = 8'h00;
        else if (t[3:0] == 4'd9) r = {t[7:4] + 4'd1, 4'd0};
        return r;
    endfunction

    // Prescaler holds while paused so a resume finishes the partial second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc  <= '0;
            time_q <= 8'h00;
        end else if (do_clear) begin
            presc  <= '0;
            time_q <= 8'h00;
        end else begin
            if (tick)        presc <= '0;
            else if (is_run) presc <= presc + 1'b1;
            if (tick) time_q <= bcd_inc(time_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q       <= 8'h00;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= do_lap;
            if (do_lap) sample_q <= time_q;
        end
    end

    assign bus.time_bcd     = time_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.running      = is_run;
endmodule
